// File: rtl/ravenoc_pkg.sv
// Shared NoC flit types: request/response link structs and flit-type encoding.
package ravenoc_pkg;

    localparam int unsigned FlitWidth   = 34;
    localparam int unsigned FlitTpWidth = 2;
    localparam int unsigned VcIdWidth   = 2;

    typedef enum logic [FlitTpWidth-1:0] {
        HEAD_FLIT      = 2'd0,
        BODY_FLIT      = 2'd1,
        TAIL_FLIT      = 2'd2,
        HEAD_TAIL_FLIT = 2'd3
    } flit_type_t;

    typedef struct packed {
        logic                 fvalid;
        logic [VcIdWidth-1:0] vc_id;
        logic [FlitWidth-1:0] flit_data;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

    // Flit type occupies the top bits of the flit word.
    function automatic flit_type_t get_flit_type(input logic [FlitWidth-1:0] flit);
        return flit_type_t'(flit[FlitWidth-1 -: FlitTpWidth]);
    endfunction

endpackage

// File: rtl/output_module_if.sv
// Link bundle of one router output port: per-input flit links, downstream link, status.
interface output_module_if #(
    parameter int unsigned NumInputs = 4
) ();
    import ravenoc_pkg::*;

    s_flit_req_t  [NumInputs-1:0] fin_req_i;
    s_flit_resp_t [NumInputs-1:0] fin_resp_o;
    logic         [NumInputs-1:0] port_sel_i;
    s_flit_req_t                  fout_req_o;
    s_flit_resp_t                 fout_resp_i;
    logic         [NumInputs-1:0] grant_o;
    logic                         full_o;
    logic                         empty_o;

    modport slave (
        input  fin_req_i, port_sel_i, fout_resp_i,
        output fin_resp_o, fout_req_o, grant_o, full_o, empty_o
    );

    modport master (
        output fin_req_i, port_sel_i, fout_resp_i,
        input  fin_resp_o, fout_req_o, grant_o, full_o, empty_o
    );

endinterface

// File: rtl/output_module_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from one above the
// last recorded winner; the winner is recorded only on the update strobe.
module rr_arbiter #(
    parameter int unsigned NumInputs = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [NumInputs-1:0] req_i,
    input  logic                 update_i,
    output logic [NumInputs-1:0] grant_o
);

    localparam int unsigned IdxW = (NumInputs > 1) ? $clog2(NumInputs) : 1;

    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] idx;
    logic            found;

    always_comb begin
        grant_o = '0;
        win_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NumInputs; k++) begin
            idx = IdxW'((32'(last_q) + k) % NumInputs);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                win_idx      = idx;
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            last_q <= '0;
        end else if (update_i && found) begin
            last_q <= win_idx;
        end
    end

endmodule

// File: rtl/output_module.sv
// Router output port: wormhole lock per packet, round-robin among requesting
// inputs, and a small output flit FIFO towards the downstream link.
module output_module #(
    parameter int unsigned NumInputs   = 4,
    parameter int unsigned OutBufDepth = 2
) (
    input logic            clk,
    input logic            arst,
    output_module_if.slave bus
);
    import ravenoc_pkg::*;

    localparam int unsigned PtrW = $clog2(OutBufDepth);
    localparam int unsigned EntW = VcIdWidth + FlitWidth;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [NumInputs-1:0] req, arb_req, arb_grant, grant, owner_q;
    logic                 update, push, pop, xfer, drop;
    s_flit_req_t          sel_flit;
    flit_type_t           sel_type;

    logic [EntW-1:0]      mem_q [OutBufDepth];
    logic [EntW-1:0]      rd_ent;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q;
    logic                 full, empty, err_q;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            req[i] = bus.fin_req_i[i].fvalid & bus.port_sel_i[i];
        end
    end

    // While locked, the owner is the only request, so the arbiter's grant is
    // the owner and the update strobe on TAIL moves the pointer past it.
    assign arb_req = (state_q == LOCKED) ? owner_q : req;

    rr_arbiter #(.NumInputs(NumInputs)) u_rr_arbiter (
        .clk      (clk),
        .arst     (arst),
        .req_i    (arb_req),
        .update_i (update),
        .grant_o  (arb_grant)
    );

    assign grant = arst ? arb_grant : '0;

    always_comb begin
        sel_flit = '0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            if (grant[i]) begin
                sel_flit = bus.fin_req_i[i];
            end
        end
    end

    assign sel_type = get_flit_type(sel_flit.flit_data);
    assign full     = (count_q == (PtrW+1)'(OutBufDepth));
    assign empty    = (count_q == '0);
    assign xfer     = (|grant) & ~full & sel_flit.fvalid;
    assign pop      = ~empty & bus.fout_resp_i.ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (xfer && sel_type == HEAD_FLIT) state_d = LOCKED;
            LOCKED:  if (xfer && sel_type == TAIL_FLIT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push   = 1'b0;
        drop   = 1'b0;
        update = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    unique case (sel_type)
                        HEAD_FLIT:      push = 1'b1;
                        HEAD_TAIL_FLIT: begin push = 1'b1; update = 1'b1; end
                        default:        drop = 1'b1;
                    endcase
                end
            end
            LOCKED: begin
                push   = xfer;
                update = xfer & (sel_type == TAIL_FLIT);
            end
            default: ;
        endcase
        bus.grant_o = grant;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            bus.fin_resp_o[i].ready = grant[i] & ~full;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && xfer && sel_type == HEAD_FLIT) owner_q <= grant;
            if (drop) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {sel_flit.vc_id, sel_flit.flit_data};
    end

    assign rd_ent = mem_q[rd_ptr_q];

    always_comb begin
        bus.fout_req_o.fvalid    = ~empty;
        bus.fout_req_o.vc_id     = rd_ent[EntW-1 -: VcIdWidth];
        bus.fout_req_o.flit_data = rd_ent[FlitWidth-1:0];
        bus.full_o               = full;
        bus.empty_o              = empty;
    end

endmodule

// File: tb/tb_output_module.sv
// Directed scenarios plus randomized packet traffic for output_module, checked
// cycle by cycle against a queue-based reference model of the output port.
module tb_output_module;
    import ravenoc_pkg::*;

    localparam int unsigned N        = 4;
    localparam int unsigned D        = 2;
    localparam int unsigned SrcDepth = 64;

    logic clk;
    logic arst;

    output_module_if #(.NumInputs(N)) bus ();

    output_module #(.NumInputs(N), .OutBufDepth(D)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [35:0] src_mem [N][SrcDepth];
    int          src_rd  [N];
    int          src_wr  [N];

    logic [35:0] m_q[$];
    int          m_last;
    int          m_owner;
    bit          m_err;

    logic [35:0] out_log[$];
    int          acc_obs [N];
    bit          dready;

    logic [N-1:0] obs_grant;
    logic [N-1:0] obs_ready;
    logic         obs_fvalid;
    logic         obs_full;
    logic [35:0]  obs_data;

    function automatic logic [35:0] mk(flit_type_t t, logic [1:0] vc, logic [31:0] pl);
        return {vc, t, pl};
    endfunction

    function automatic flit_type_t tp(logic [35:0] w);
        return flit_type_t'(w[33:32]);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enq(int i, logic [35:0] w);
        src_mem[i][src_wr[i]] = w;
        src_wr[i]++;
    endtask

    task automatic enq_pkt(int i, int len, logic [1:0] vc, logic [31:0] base);
        if (len == 1) begin
            enq(i, mk(HEAD_TAIL_FLIT, vc, base));
        end else begin
            for (int k = 0; k < len; k++) begin
                enq(i, mk((k == 0) ? HEAD_FLIT : (k == len-1) ? TAIL_FLIT : BODY_FLIT,
                          vc, base + 32'(k)));
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        out_log.delete();
        m_last  = 0;
        m_owner = -1;
        m_err   = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_rd[i]  = 0;
            src_wr[i]  = 0;
            acc_obs[i] = 0;
        end
    endtask

    // Reset with every input requesting: nothing may be granted or offered.
    task automatic do_reset();
        logic [N-1:0] rv;
        arst   = 1'b0;
        dready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.fin_req_i[i] = '{fvalid: 1'b1, vc_id: 2'd1, flit_data: mk(HEAD_FLIT, 2'd1, 32'h77)};
            bus.port_sel_i[i] = 1'b1;
        end
        bus.fout_resp_i.ready = 1'b1;
        #1;
        for (int i = 0; i < N; i++) rv[i] = bus.fin_resp_o[i].ready;
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_ready", rv, 0);
        chk("rst_fvalid", bus.fout_req_o.fvalid, 0);
        chk("rst_full", bus.full_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        arst = 1'b1;
    endtask

    // One clock: drive sources, check DUT against the model, advance the model.
    task automatic step();
        logic [N-1:0] fv, eg, er;
        logic [35:0]  w;
        int           g, idx;
        bit           full_m;
        for (int i = 0; i < N; i++) begin
            fv[i] = (src_rd[i] < src_wr[i]);
            w     = fv[i] ? src_mem[i][src_rd[i]] : '0;
            bus.fin_req_i[i]  = '{fvalid: fv[i], vc_id: w[35:34], flit_data: w[33:0]};
            bus.port_sel_i[i] = fv[i];
        end
        bus.fout_resp_i.ready = dready;
        #1;
        obs_grant  = bus.grant_o;
        for (int i = 0; i < N; i++) obs_ready[i] = bus.fin_resp_o[i].ready;
        obs_fvalid = bus.fout_req_o.fvalid;
        obs_data   = {bus.fout_req_o.vc_id, bus.fout_req_o.flit_data};
        obs_full   = bus.full_o;

        full_m = (m_q.size() == D);
        g = -1;
        if (m_owner >= 0) begin
            g = m_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && fv[idx]) g = idx;
            end
        end
        eg = '0;
        er = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            er[g] = !full_m;
        end
        chk("grant", obs_grant, eg);
        chk("ready", obs_ready, er);
        chk("fvalid", obs_fvalid, m_q.size() != 0);
        if (m_q.size() != 0) chk("fdata", obs_data, m_q[0]);
        chk("full", obs_full, full_m);
        chk("empty", bus.empty_o, m_q.size() == 0);
        chk("err", dut.err_q, m_err);

        if (obs_fvalid && dready) out_log.push_back(obs_data);
        for (int i = 0; i < N; i++) if (obs_ready[i] && fv[i]) acc_obs[i]++;

        if (m_q.size() != 0 && dready) void'(m_q.pop_front());
        if (g >= 0 && fv[g] && !full_m) begin
            w = src_mem[g][src_rd[g]];
            src_rd[g]++;
            if (m_owner < 0) begin
                case (tp(w))
                    HEAD_FLIT:      begin m_q.push_back(w); m_owner = g; end
                    HEAD_TAIL_FLIT: begin m_q.push_back(w); m_last = g; end
                    default:        m_err = 1'b1;
                endcase
            end else begin
                m_q.push_back(w);
                if (tp(w) == TAIL_FLIT) begin
                    m_owner = -1;
                    m_last  = g;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [35:0]  w1;
        logic [35:0]  exp6 [6];
        logic [N-1:0] gseq [5];
        logic [N-1:0] gexp [5];

        arst = 1'b0;
        do_reset();

        // Lone HEAD_TAIL from input 2 appears one cycle after acceptance.
        w1 = mk(HEAD_TAIL_FLIT, 2'd3, 32'hA5A5_0002);
        enq(2, w1);
        step();
        step();
        chk("s1_fvalid", obs_fvalid, 1);
        chk("s1_data", obs_data, w1);
        chk("s1_grant_clr", obs_grant, 0);
        step();

        // Two simultaneous 3-flit packets must not interleave.
        out_log.delete();
        enq_pkt(0, 3, 2'd0, 32'h1000);
        enq_pkt(1, 3, 2'd1, 32'h2000);
        repeat (10) step();
        exp6[0] = mk(HEAD_FLIT, 2'd0, 32'h1000);
        exp6[1] = mk(BODY_FLIT, 2'd0, 32'h1001);
        exp6[2] = mk(TAIL_FLIT, 2'd0, 32'h1002);
        exp6[3] = mk(HEAD_FLIT, 2'd1, 32'h2000);
        exp6[4] = mk(BODY_FLIT, 2'd1, 32'h2001);
        exp6[5] = mk(TAIL_FLIT, 2'd1, 32'h2002);
        chk("s2_count", out_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("s2_order", (k < out_log.size()) ? out_log[k] : '1, exp6[k]);
        end

        // Everyone streaming HEAD_TAIL: rotation starts at input 1 after reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) enq(i, mk(HEAD_TAIL_FLIT, 2'd2, 32'(i*16 + k)));
        end
        gexp[0] = 4'b0010; gexp[1] = 4'b0100; gexp[2] = 4'b1000;
        gexp[3] = 4'b0001; gexp[4] = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            step();
            gseq[k] = obs_grant;
        end
        for (int k = 0; k < 5; k++) chk("s3_rr_order", gseq[k], gexp[k]);
        repeat (12) step();

        // Downstream stalled: only D flits accepted, nothing lost afterwards.
        out_log.delete();
        for (int i = 0; i < N; i++) acc_obs[i] = 0;
        dready = 1'b0;
        enq_pkt(0, 4, 2'd1, 32'h4000);
        repeat (10) step();
        chk("s4_accepted", acc_obs[0], D);
        chk("s4_full", obs_full, 1);
        chk("s4_owner_ready", obs_ready[0], 0);
        dready = 1'b1;
        repeat (8) step();
        chk("s4_delivered", out_log.size(), 4);
        chk("s4_last", (out_log.size() == 4) ? out_log[3] : '1, mk(TAIL_FLIT, 2'd1, 32'h4003));

        // Reset right after a HEAD is accepted: nothing emerges afterwards.
        do_reset();
        enq_pkt(1, 4, 2'd0, 32'h5000);
        step();
        do_reset();
        repeat (4) step();
        chk("s5_no_output", out_log.size(), 0);
        chk("s5_empty", bus.empty_o, 1);
        chk("s5_grant", obs_grant, 0);

        // Stray BODY while idle is swallowed and flagged.
        enq(3, mk(BODY_FLIT, 2'd2, 32'h6000));
        step();
        step();
        chk("s6_err", dut.err_q, 1);
        chk("s6_fvalid", obs_fvalid, 0);

        // Random packet traffic with random downstream backpressure.
        do_reset();
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (src_rd[i] == src_wr[i]) begin
                    src_rd[i] = 0;
                    src_wr[i] = 0;
                    if ($urandom_range(0, 3) == 0) begin
                        enq_pkt(i, int'($urandom_range(1, 4)), 2'($urandom_range(0, 3)), $urandom);
                    end
                end
            end
            dready = ($urandom_range(0, 3) != 0);
            step();
        end
        dready = 1'b1;
        repeat (40) step();
        chk("drain_empty", bus.empty_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
